// File: rtl/rib_arbiter_pkg.sv
// rib_arbiter_pkg
//   Shared constants for the RIB arbiter slice: FSM state encodings, master
//   index values, the "no owner" grant code and the memory bus widths.
//   No ports; imported by rib_arbiter and rib_arb_pick.
//   Optional build macro used by the importers: RIB_ARB_RR_EN.
package rib_arbiter_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] M0       = 2'd0;
  localparam logic [1:0] M1       = 2'd1;
  localparam logic [1:0] M2       = 2'd2;
  localparam logic [1:0] GNT_NONE = 2'd3;

  // One-hot mask of the master addressed by a grant code; GNT_NONE maps to
  // an empty mask so the response fan-out never touches a non-owner.
  function automatic logic [2:0] owner_mask(input logic [1:0] gnt);
    logic [2:0] mask;
    mask = 3'b000;
    case (gnt)
      M0:      mask = 3'b001;
      M1:      mask = 3'b010;
      M2:      mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rib_arb_pick.sv
// rib_arb_pick
//   Combinational winner selection for the RIB arbiter.
//   Ports:
//     req   [2:0] in   request vector, bit N = master N
//     ptr   [1:0] in   last granted master (only used for round-robin)
//     valid       out  at least one master is requesting
//     idx   [1:0] out  winning master index (GNT_NONE when nobody requests)
//   Build macro RIB_ARB_RR_EN selects round-robin (search starts at ptr+1
//   mod 3); without it the order is fixed m2 > m0 > m1.
module rib_arb_pick
  import rib_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  assign valid = |req;

`ifdef RIB_ARB_RR_EN
  // Rotate the search so the master after the last winner is looked at
  // first; the pointer never holds 3, so the default arm covers ptr==2.
  always_comb begin
    idx = GNT_NONE;
    case (ptr)
      M0: begin
        if (req[1])      idx = M1;
        else if (req[2]) idx = M2;
        else if (req[0]) idx = M0;
      end
      M1: begin
        if (req[2])      idx = M2;
        else if (req[0]) idx = M0;
        else if (req[1]) idx = M1;
      end
      default: begin
        if (req[0])      idx = M0;
        else if (req[1]) idx = M1;
        else if (req[2]) idx = M2;
      end
    endcase
  end
`else
  // Fixed priority: debug access first so JTAG can always get through,
  // then data accesses ahead of instruction fetch.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx = GNT_NONE;
    if (req[2])      idx = M2;
    else if (req[0]) idx = M0;
    else if (req[1]) idx = M1;
  end
`endif

endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter
//   Registered request/grant arbiter sharing one RIB slave port between
//   m0 (core load/store), m1 (core fetch) and m2 (JTAG debug access).
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     mN_req_i/we_i/addr_i/data_i  master N request and write fields
//     mN_data_o/ack_o/err_o        master N response (owner only)
//     bus_req_o/we_o/addr_o/data_o latched request to the slave port
//     bus_data_i/ack_i             slave response
//     hold_flag_o                  core master waiting (stall the pipeline)
//     gnt_o                        current owner, 3 = none
//   Parameter TIMEOUT (1..255): BUSY cycles without an ack before the
//   transaction is terminated with an error.
//   Build macro RIB_ARB_RR_EN: round-robin arbitration instead of fixed.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [MemAddrBus-1:0] m0_addr_i,
  input  logic [MemBus-1:0]     m0_data_i,
  output logic [MemBus-1:0]     m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [MemAddrBus-1:0] m1_addr_i,
  input  logic [MemBus-1:0]     m1_data_i,
  output logic [MemBus-1:0]     m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  input  logic                  m2_req_i,
  input  logic                  m2_we_i,
  input  logic [MemAddrBus-1:0] m2_addr_i,
  input  logic [MemBus-1:0]     m2_data_i,
  output logic [MemBus-1:0]     m2_data_o,
  output logic                  m2_ack_o,
  output logic                  m2_err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [MemAddrBus-1:0] bus_addr_o,
  output logic [MemBus-1:0]     bus_data_o,
  input  logic [MemBus-1:0]     bus_data_i,
  input  logic                  bus_ack_i,
  output logic                  hold_flag_o,
  output logic [1:0]            gnt_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            state;
  logic [7:0]            cnt;
  logic [MemBus-1:0]     rdata;
  logic                  err;
  logic                  pick_valid;
  logic [1:0]            pick_idx;
  logic [1:0]            rr_ptr;
  logic                  sel_we;
  logic [MemAddrBus-1:0] sel_addr;
  logic [MemBus-1:0]     sel_wdata;
  logic [2:0]            ack_vec;

  rib_arb_pick u_pick (
    .req   ({m2_req_i, m1_req_i, m0_req_i}),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef RIB_ARB_RR_EN
  // The pointer remembers who was granted last; it moves only when a new
  // transaction actually starts, so idle cycles do not disturb fairness.
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= M0;
    else if (state == ST_IDLE && pick_valid)
      rr_ptr <= pick_idx;
  end
`else
  assign rr_ptr = M0;
`endif

  // Route the winning master's request fields to the latch inputs.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (pick_idx)
      M0: begin sel_we = m0_we_i; sel_addr = m0_addr_i; sel_wdata = m0_data_i; end
      M1: begin sel_we = m1_we_i; sel_addr = m1_addr_i; sel_wdata = m1_data_i; end
      M2: begin sel_we = m2_we_i; sel_addr = m2_addr_i; sel_wdata = m2_data_i; end
      default: ;
    endcase
  end

  // Main FSM. The bus fields are latched once on grant and held through
  // BUSY so the slave sees stable values even if the master changes its
  // inputs or drops its request. A reset mid-transaction simply returns to
  // IDLE; the owner never gets an ack for the abandoned access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt_o      <= GNT_NONE;
      bus_we_o   <= 1'b0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      cnt        <= 8'd0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_o      <= pick_idx;
            bus_we_o   <= sel_we;
            bus_addr_o <= sel_addr;
            bus_data_o <= sel_wdata;
            cnt        <= 8'd0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ack_i) begin
            rdata <= bus_data_i;
            err   <= 1'b0;
            state <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            rdata <= '0;
            err   <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          gnt_o <= GNT_NONE;
        end
        default: begin
          state <= ST_IDLE;
          gnt_o <= GNT_NONE;
        end
      endcase
    end
  end

  // Response fan-out: only the owner sees ack/err/data, and only in RESP.
  assign ack_vec   = (state == ST_RESP) ? owner_mask(gnt_o) : 3'b000;
  assign bus_req_o = (state == ST_BUSY);

  assign m0_ack_o  = ack_vec[0];
  assign m1_ack_o  = ack_vec[1];
  assign m2_ack_o  = ack_vec[2];
  assign m0_err_o  = ack_vec[0] & err;
  assign m1_err_o  = ack_vec[1] & err;
  assign m2_err_o  = ack_vec[2] & err;
  assign m0_data_o = ack_vec[0] ? rdata : '0;
  assign m1_data_o = ack_vec[1] ? rdata : '0;
  assign m2_data_o = ack_vec[2] ? rdata : '0;

  // Stall the core while either of its ports is waiting; the ack cycle
  // itself releases the stall so the pipeline can consume the data.
  assign hold_flag_o = (m0_req_i & ~m0_ack_o) | (m1_req_i & ~m1_ack_o);

endmodule
